stump_mem_model: RTL and testbench
==================================

STUMP_MEM_MODEL -- requirements
Module: stump_mem_model

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- DATA_W, 16, data width
- ADDR_W, 16, address width
- DEPTH_LOG2, 10, log2 of words stored
- WAIT_STATES, 0, extra cycles per access, legal range 0-7
- TIMEOUT, 200, cycle limit after reset
- HALT_ADDR, all ones (ADDR_W), stop address
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1, system clock (rising edge)
- rst, in, 1, reset, asynchronous, active-high
- address, in, ADDR_W, access address
- data_out, in, DATA_W, write data from processor
- mem_wen, in, 1, write request
- mem_ren, in, 1, read request
- data_in, out, DATA_W, read data to processor
- ready, out, 1, access complete this cycle
- halt, out, 1, sticky stop flag
- timeout, out, 1, sticky time-limit flag
- err, out, 1, sticky protocol error

Function
REQ-003 SHALL store 2^DEPTH_LOG2 words; array index = address[DEPTH_LOG2-1:0]; upper address bits ignored (aliasing wraps).
REQ-004 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; the request is sampled in IDLE on a rising edge with mem_ren or mem_wen high.
REQ-005 WAIT_STATES=0: SHALL go IDLE -> DONE directly; ready high for exactly 1 cycle, on the cycle after the request edge.
REQ-006 WAIT_STATES=N>0: SHALL stay in WAIT for N cycles (down-counter loaded with N); ready high for 1 cycle after the count reaches zero; latency = N+1 cycles.
REQ-007 SHALL latch address, data_out and the read/write request at acceptance; input changes during WAIT/DONE SHALL be ignored.
REQ-008 Write: array word SHALL update on the clk edge entering DONE; data_in SHALL hold its previous value.
REQ-009 Read: data_in SHALL be registered and valid in DONE while ready=1; it SHALL hold that value until the next read completes.
REQ-010 Read-after-write to the same address SHALL return the newly written data.
REQ-011 mem_wen and mem_ren high together: SHALL perform the write only and set err.
REQ-012 Requests arriving while not in IDLE SHALL NOT be queued; the processor holds its request until ready.
REQ-013 A write to HALT_ADDR (full ADDR_W compare) SHALL NOT modify the array; it completes with normal latency, and halt sets on the DONE edge.
REQ-014 Once halt=1, new requests SHALL be ignored: ready stays 0, the array is frozen, FSM stays IDLE.
REQ-015 SHALL count cycles after reset deassertion in a saturating counter wide enough for TIMEOUT; timeout sets when the count reaches TIMEOUT; accesses continue after timeout.
REQ-016 halt, timeout and err SHALL be sticky until rst.
REQ-017 Reads of never-written words SHALL return the preloaded contents (simulation preload from a hex file supported); contents are otherwise undefined.

Reset
REQ-018 rst high SHALL immediately force: FSM=IDLE, ready=0, data_in=0, halt=0, timeout=0, err=0, cycle counter=0, wait counter=0.
REQ-019 rst during WAIT/DONE SHALL abort the access with no array write; array contents SHALL NOT be cleared by reset.
REQ-020 First request SHALL be accepted on the first rising edge after rst falls.

Verification
REQ-021 WAIT_STATES=0: write 0x1234 to 0x0010, then read 0x0010 -> ready 1 cycle after each request; data_in=0x1234.
REQ-022 WAIT_STATES=3: read 0x0005 preloaded with 0xBEEF -> ready exactly 4 cycles after acceptance; data_in=0xBEEF; address changed mid-wait has no effect.
REQ-023 DEPTH_LOG2=10: write 0xAAAA to 0x0403, read 0x0003 -> 0xAAAA (aliasing).
REQ-024 Write 0x0001 to 0xFFFF -> halt=1, array unchanged; a subsequent read gives ready=0 forever.
REQ-025 Assert ren and wen together on 0x0020 with data 0x5555 -> word becomes 0x5555, err=1; no access for TIMEOUT=200 cycles -> timeout=1 at cycle 200.
REQ-026 WAIT_STATES=5: rst asserted during a write to 0x0030 -> all outputs reset at once, word at 0x0030 unchanged.

Source files
------------

// File: rtl/stump_mem_model.sv
// Behavioural memory for the Stump core: fixed-latency
// handshake, halt-on-write stop address, run-time limit.
module stump_mem_model #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH_LOG2  = 10,
  parameter int                WAIT_STATES = 0,
  parameter int                TIMEOUT     = 200,
  parameter logic [ADDR_W-1:0] HALT_ADDR   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_out,
  input  logic              mem_wen,
  input  logic              mem_ren,
  output logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              halt,
  output logic              timeout,
  output logic              err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [WORDS];
  logic [ADDR_W-1:0]   a_q;
  logic [DATA_W-1:0]   d_q;
  logic                wr_q;
  logic [2:0]          wcnt;
  logic [CW-1:0]       cyc;

  logic                req;
  logic                go;
  logic                c_wr;
  logic [ADDR_W-1:0]   c_a;
  logic [DATA_W-1:0]   c_d;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                c_halt;

  assign req = mem_wen | mem_ren;

  // Access completing on this edge: zero-wait accesses use
  // the live inputs, delayed ones use the latched request.
  always_comb begin
    go   = 1'b0;
    c_wr = wr_q;
    c_a  = a_q;
    c_d  = d_q;
    if (!rst) begin
      if (state == S_IDLE && req && !halt && WS == 3'd0) begin
        go   = 1'b1;
        c_wr = mem_wen;
        c_a  = address;
        c_d  = data_out;
      end else if (state == S_WAIT && wcnt == 3'd1) begin
        go = 1'b1;
      end
    end
  end

  assign c_idx  = c_a[DEPTH_LOG2-1:0];
  assign c_halt = (c_a == HALT_ADDR);

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (go && c_wr && !c_halt)
      mem[c_idx] <= c_d;
  end

  // Handshake FSM, read data, sticky flags, cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ready   <= 1'b0;
      data_in <= '0;
      halt    <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
      cyc     <= '0;
      wcnt    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      wr_q    <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (cyc < T_MAX)
        cyc <= cyc + CW'(1);
      if (TIMEOUT == 0 || cyc == T_LAST)
        timeout <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (req && !halt) begin
            a_q  <= address;
            d_q  <= data_out;
            wr_q <= mem_wen;
            if (mem_wen && mem_ren)
              err <= 1'b1;
            if (WS == 3'd0) begin
              state <= S_DONE;
              ready <= 1'b1;
            end else begin
              state <= S_WAIT;
              wcnt  <= WS;
            end
          end
        end
        S_WAIT: begin
          wcnt <= wcnt - 3'd1;
          if (wcnt == 3'd1) begin
            state <= S_DONE;
            ready <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go) begin
        if (c_wr) begin
          if (c_halt)
            halt <= 1'b1;
        end else begin
          data_in <= mem[c_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_stump_mem_model.sv
// Directed bench for stump_mem_model: three instances
// with 0, 3 and 5 wait states.
module tb_stump_mem_model;

  logic        clk;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        rst_v  [3];
  logic        wen_v  [3];
  logic        ren_v  [3];
  logic [15:0] din_v  [3];
  logic        rdy_v  [3];
  logic        halt_v [3];
  logic        to_v   [3];
  logic        err_v  [3];

  int nerr = 0;
  int nchk = 0;

  stump_mem_model #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .address(address),
    .data_out(data_out), .mem_wen(wen_v[0]),
    .mem_ren(ren_v[0]), .data_in(din_v[0]),
    .ready(rdy_v[0]), .halt(halt_v[0]),
    .timeout(to_v[0]), .err(err_v[0])
  );

  stump_mem_model #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst_v[1]), .address(address),
    .data_out(data_out), .mem_wen(wen_v[1]),
    .mem_ren(ren_v[1]), .data_in(din_v[1]),
    .ready(rdy_v[1]), .halt(halt_v[1]),
    .timeout(to_v[1]), .err(err_v[1])
  );

  stump_mem_model #(.WAIT_STATES(5)) u5 (
    .clk(clk), .rst(rst_v[2]), .address(address),
    .data_out(data_out), .mem_wen(wen_v[2]),
    .mem_ren(ren_v[2]), .data_in(din_v[2]),
    .ready(rdy_v[2]), .halt(halt_v[2]),
    .timeout(to_v[2]), .err(err_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    bit          r;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] e_din;
    bit          e_err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_rst(input int k);
    @(negedge clk);
    wen_v[k] = 1'b0;
    ren_v[k] = 1'b0;
    rst_v[k] = 1'b1;
    @(negedge clk);
    rst_v[k] = 1'b0;
  endtask

  // lat = edges from acceptance until ready seen, 0 if never
  task automatic access(input int k, input bit w,
                        input bit r,
                        input logic [15:0] a,
                        input logic [15:0] d,
                        input bit chg,
                        output int lat);
    @(negedge clk);
    address  = a;
    data_out = d;
    wen_v[k] = w;
    ren_v[k] = r;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1 && chg) begin
        address  = a ^ 16'h00F0;
        data_out = ~d;
      end
    end while (!rdy_v[k] && lat < 20);
    if (!rdy_v[k])
      lat = 0;
    @(negedge clk);
    wen_v[k] = 1'b0;
    ren_v[k] = 1'b0;
    if (lat != 0) begin
      @(posedge clk);
      #1;
      chk("ready_one_cycle", 32'(rdy_v[k]), 0);
    end
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    address  = '0;
    data_out = '0;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b0;
      wen_v[i] = 1'b0;
      ren_v[i] = 1'b0;
    end
    tbl[0]  = '{1, 0, 16'h0010, 16'h1234, 16'h0000, 0};
    tbl[1]  = '{0, 1, 16'h0010, 16'h0000, 16'h1234, 0};
    tbl[2]  = '{1, 0, 16'h0403, 16'hAAAA, 16'h1234, 0};
    tbl[3]  = '{0, 1, 16'h0003, 16'h0000, 16'hAAAA, 0};
    tbl[4]  = '{1, 0, 16'h0011, 16'h0F0F, 16'hAAAA, 0};
    tbl[5]  = '{0, 1, 16'h0011, 16'h0000, 16'h0F0F, 0};
    tbl[6]  = '{0, 1, 16'h0010, 16'h0000, 16'h1234, 0};
    tbl[7]  = '{1, 0, 16'h0010, 16'h4321, 16'h1234, 0};
    tbl[8]  = '{0, 1, 16'h0410, 16'h0000, 16'h4321, 0};
    tbl[9]  = '{1, 1, 16'h0020, 16'h5555, 16'h4321, 1};
    tbl[10] = '{0, 1, 16'h0020, 16'h0000, 16'h5555, 1};
    tbl[11] = '{1, 0, 16'h03FF, 16'h7777, 16'h5555, 1};

    #1;
    for (int i = 0; i < 3; i++)
      rst_v[i] = 1'b1;
    #1;
    chk("rst_ready", 32'(rdy_v[0]), 0);
    chk("rst_din", 32'(din_v[0]), 0);
    chk("rst_halt", 32'(halt_v[0]), 0);
    chk("rst_timeout", 32'(to_v[0]), 0);
    chk("rst_err", 32'(err_v[0]), 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      rst_v[i] = 1'b0;

    for (int i = 0; i < 12; i++) begin
      access(0, tbl[i].w, tbl[i].r, tbl[i].a,
             tbl[i].d, 0, lat);
      chk($sformatf("ws0_lat_%0d", i), 32'(lat), 1);
      chk($sformatf("ws0_din_%0d", i),
          32'(din_v[0]), 32'(tbl[i].e_din));
      chk($sformatf("ws0_err_%0d", i),
          32'(err_v[0]), 32'(tbl[i].e_err));
      chk($sformatf("ws0_halt_%0d", i),
          32'(halt_v[0]), 0);
    end

    access(0, 1, 0, 16'hFFFF, 16'h0001, 0, lat);
    chk("halt_lat", 32'(lat), 1);
    chk("halt_set", 32'(halt_v[0]), 1);
    chk("halt_word", 32'(u0.mem[1023]), 32'h7777);
    access(0, 0, 1, 16'h0010, 16'h0000, 0, lat);
    chk("halt_no_ready", 32'(lat), 0);
    chk("halt_din_hold", 32'(din_v[0]), 32'h5555);
    access(0, 1, 0, 16'h0011, 16'hDEAD, 0, lat);
    chk("halt_frozen", 32'(u0.mem[17]), 32'h0F0F);
    chk("halt_sticky", 32'(halt_v[0]), 1);

    do_rst(1);
    repeat (199) @(posedge clk);
    #1;
    chk("timeout_199", 32'(to_v[1]), 0);
    @(posedge clk);
    #1;
    chk("timeout_200", 32'(to_v[1]), 1);
    access(1, 1, 0, 16'h0005, 16'hBEEF, 0, lat);
    chk("ws3_wr_lat", 32'(lat), 4);
    access(1, 0, 1, 16'h0005, 16'h0000, 1, lat);
    chk("ws3_rd_lat", 32'(lat), 4);
    chk("ws3_rd_din", 32'(din_v[1]), 32'hBEEF);
    chk("ws3_timeout_sticky", 32'(to_v[1]), 1);
    chk("ws3_err", 32'(err_v[1]), 0);

    do_rst(2);
    access(2, 1, 0, 16'h0030, 16'h1111, 0, lat);
    chk("ws5_wr_lat", 32'(lat), 6);
    access(2, 0, 1, 16'h0030, 16'h0000, 0, lat);
    chk("ws5_rd_din", 32'(din_v[2]), 32'h1111);
    @(negedge clk);
    address  = 16'h0030;
    data_out = 16'h2222;
    wen_v[2] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_v[2] = 1'b1;
    #1;
    chk("abort_ready", 32'(rdy_v[2]), 0);
    chk("abort_din", 32'(din_v[2]), 0);
    chk("abort_flags",
        32'({halt_v[2], to_v[2], err_v[2]}), 0);
    wen_v[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_word", 32'(u5.mem[48]), 32'h1111);
    rst_v[2] = 1'b0;
    access(2, 0, 1, 16'h0030, 16'h0000, 0, lat);
    chk("ws5_post_rst_lat", 32'(lat), 6);
    chk("ws5_post_rst_din", 32'(din_v[2]), 32'h1111);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
